// File: rtl/fas_pkg.sv
// Shared definitions for the FAS peak-scheduling datapath.
//   NBIN      : bins per FFT frame (freq is 4 bits, so fixed at 16)
//   DW        : width of the signed real / imaginary half of a bin word
//   MAG_W     : width of re^2+im^2 (fits exactly, max 2^31)
//   WORD_W    : width of one packed bin word {re, im}
//   state_e   : scheduler states
package fas_pkg;
    localparam int NBIN      = 16;
    localparam int DW        = 16;
    localparam int MAG_W     = 2 * DW;
    localparam int BIN_IDX_W = 4;
    localparam int WORD_W    = 2 * DW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_e;
endpackage

// File: rtl/fas_bin_mag.sv
// Combinational squared magnitude of one bin word.
//   word : {re[DW-1:0], im[DW-1:0]}, both two's complement
//   mag  : re*re + im*im, unsigned
module fas_bin_mag
    import fas_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic [MAG_W-1:0]  mag
);
    logic signed [DW-1:0]    re;
    logic signed [DW-1:0]    im;
    logic signed [MAG_W-1:0] re_sq;
    logic signed [MAG_W-1:0] im_sq;

    assign re    = word[WORD_W-1:DW];
    assign im    = word[DW-1:0];
    // Each square is non-negative and at most 2^30, so the unsigned sum
    // (at most 2^31) never wraps in MAG_W bits.
    assign re_sq = MAG_W'(re) * MAG_W'(re);
    assign im_sq = MAG_W'(im) * MAG_W'(im);
    assign mag   = $unsigned(re_sq) + $unsigned(im_sq);
endmodule

// File: rtl/fas_peak_scheduler.sv
// Scheduled peak-bin finder: captures one 16-bin FFT frame, walks the bins
// through a single magnitude unit and comparator over 16 cycles, then
// reports the peak index with a one-cycle done pulse.
//   clk, rst        : clock; asynchronous active-low reset
//   fft_valid       : frame strobe; fft_frame sampled only when accepted
//   fft_frame       : NBIN packed bin words, bin k at [k*32 +: 32]
//   busy            : frame captured and not yet reported
//   done            : one-cycle result strobe
//   freq, peak_mag  : peak bin index and its re^2+im^2, held until next done
//   overrun         : one-cycle pulse after a frame arrives during SCAN
//   drop_cnt        : saturating count of dropped frames
module fas_peak_scheduler
    import fas_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fft_valid,
    input  logic [NBIN*WORD_W-1:0] fft_frame,
    output logic                   busy,
    output logic                   done,
    output logic [BIN_IDX_W-1:0]   freq,
    output logic [MAG_W-1:0]       peak_mag,
    output logic                   overrun,
    output logic [CNT_W-1:0]       drop_cnt
);
    state_e                 state_q, state_d;
    logic [BIN_IDX_W-1:0]   idx_q, idx_d;
    logic [MAG_W-1:0]       best_mag_q, best_mag_d;
    logic [BIN_IDX_W-1:0]   best_idx_q, best_idx_d;
    logic [BIN_IDX_W-1:0]   freq_q, freq_d;
    logic [MAG_W-1:0]       peak_mag_q, peak_mag_d;
    logic                   overrun_q, overrun_d;
    logic [CNT_W-1:0]       drop_cnt_q, drop_cnt_d;
    logic [NBIN*WORD_W-1:0] frame_q, frame_d;

    logic [WORD_W-1:0]      bin_word;
    logic [MAG_W-1:0]       bin_mag;
    logic                   take;
    logic                   accept;

    assign bin_word = frame_q[int'(idx_q)*WORD_W +: WORD_W];

    fas_bin_mag u_mag (
        .word (bin_word),
        .mag  (bin_mag)
    );

    // Bin 0 seeds the search; later bins win only on strictly greater
    // magnitude so ties resolve to the lowest index.
    assign take   = (idx_q == '0) || (bin_mag > best_mag_q);
    assign accept = fft_valid && (state_q != SCAN);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        best_mag_d = best_mag_q;
        best_idx_d = best_idx_q;
        freq_d     = freq_q;
        peak_mag_d = peak_mag_q;
        overrun_d  = 1'b0;
        drop_cnt_d = drop_cnt_q;
        frame_d    = frame_q;

        case (state_q)
            IDLE, REPORT: begin
                state_d = IDLE;
                if (accept) begin
                    frame_d    = fft_frame;
                    idx_d      = '0;
                    best_mag_d = '0;
                    best_idx_d = '0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (take) begin
                    best_mag_d = bin_mag;
                    best_idx_d = idx_q;
                end
                idx_d = idx_q + 1'b1;
                // Publish on the last bin so freq/peak_mag are already
                // valid in the REPORT cycle where done is high.
                if (idx_q == BIN_IDX_W'(NBIN - 1)) begin
                    freq_d     = take ? idx_q   : best_idx_q;
                    peak_mag_d = take ? bin_mag : best_mag_q;
                    state_d    = REPORT;
                end
                if (fft_valid) begin
                    overrun_d = 1'b1;
                    if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            best_mag_q <= '0;
            best_idx_q <= '0;
            freq_q     <= '0;
            peak_mag_q <= '0;
            overrun_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            best_mag_q <= best_mag_d;
            best_idx_q <= best_idx_d;
            freq_q     <= freq_d;
            peak_mag_q <= peak_mag_d;
            overrun_q  <= overrun_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Frame buffer contents are irrelevant until a frame is accepted.
    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == REPORT);
    assign freq     = freq_q;
    assign peak_mag = peak_mag_q;
    assign overrun  = overrun_q;
    assign drop_cnt = drop_cnt_q;
endmodule
